// File: rtl/single_port_ram.sv
// 64 x 8 synchronous single-port RAM with a shared address bus and a registered,
// write-through read port. Reset clears only the output register.
module single_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto RAM macros; reset only
    // gates the write enable, which keeps stored words intact across a reset.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[addr] <= data;
        end
    end

    // NOTE: non-blocking assignments keep the read of mem[addr] from seeing the
    // write made at the same edge; write-through comes from selecting data directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (we) begin
            dout <= data;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: tb/tb_single_port_ram.sv
// Directed self-checking bench for single_port_ram: stimulus changes on the falling
// edge, dout is sampled 1 ns after each rising edge.
module tb_single_port_ram;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    single_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .addr  (addr),
        .data  (data),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One operation: drive on the falling edge, return 1 ns after the rising edge.
    task automatic op(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        rst_n = r;
        we    = w;
        addr  = a;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            op(1'b0, 1'b1, 6'd0, 8'hFF);
            n_cmp++;
            if (dout !== 8'h00) begin
                n_err++;
                $display("FAIL reset_cycle%0d: dout=%h required=00", i, dout);
            end
        end
        // Word 0 was never written, so it must not hold the FF offered during reset.
        op(1'b1, 1'b0, 6'd0, 8'h00);
        n_cmp++;
        if (dout === 8'hFF) begin
            n_err++;
            $display("FAIL reset_write_suppressed: dout=%h required=not FF", dout);
        end
    endtask

    task automatic test_sequential_writes();
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b1, 6'(i), 8'(i + 1));
            n_cmp++;
            if (dout !== 8'(i + 1)) begin
                n_err++;
                $display("FAIL seq_write@%0d: dout=%h required=%h", i, dout, 8'(i + 1));
            end
        end
    endtask

    task automatic test_readback();
        op(1'b1, 1'b0, 6'd0, 8'h00);
        n_cmp++;
        if (dout !== 8'h01) begin
            n_err++;
            $display("FAIL readback@0: dout=%h required=01", dout);
        end
        op(1'b1, 1'b0, 6'd1, 8'h00);
        n_cmp++;
        if (dout !== 8'h02) begin
            n_err++;
            $display("FAIL readback@1: dout=%h required=02", dout);
        end
        // Change the address mid-cycle; dout must hold until the next rising edge.
        #1;
        addr = 6'd2;
        #2;
        n_cmp++;
        if (dout !== 8'h02) begin
            n_err++;
            $display("FAIL readback_hold: dout=%h required=02", dout);
        end
    endtask

    task automatic test_back_to_back();
        logic       w_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [5:0] a_t [4] = '{6'd3, 6'd4, 6'd3, 6'd4};
        logic [7:0] d_t [4] = '{8'h04, 8'h05, 8'h00, 8'h00};
        logic [7:0] e_t [4] = '{8'h04, 8'h05, 8'h04, 8'h05};
        for (int i = 0; i < 4; i++) begin
            op(1'b1, w_t[i], a_t[i], d_t[i]);
            n_cmp++;
            if (dout !== e_t[i]) begin
                n_err++;
                $display("FAIL interleaved_step%0d: dout=%h required=%h", i, dout, e_t[i]);
            end
        end
    endtask

    task automatic test_overwrite_boundary();
        logic       w_t [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [5:0] a_t [6] = '{6'd63, 6'd63, 6'd63, 6'd0, 6'd63, 6'd0};
        logic [7:0] d_t [6] = '{8'hAA, 8'h55, 8'h00, 8'h3C, 8'h00, 8'h00};
        logic [7:0] e_t [6] = '{8'hAA, 8'h55, 8'h55, 8'h3C, 8'h55, 8'h3C};
        for (int i = 0; i < 6; i++) begin
            op(1'b1, w_t[i], a_t[i], d_t[i]);
            n_cmp++;
            if (dout !== e_t[i]) begin
                n_err++;
                $display("FAIL overwrite_step%0d: dout=%h required=%h", i, dout, e_t[i]);
            end
        end
    endtask

    task automatic test_reset_retention();
        // Reset with a write request to word 2: output clears, write is dropped.
        op(1'b0, 1'b1, 6'd2, 8'hEE);
        n_cmp++;
        if (dout !== 8'h00) begin
            n_err++;
            $display("FAIL retention_reset: dout=%h required=00", dout);
        end
        op(1'b1, 1'b0, 6'd2, 8'h00);
        n_cmp++;
        if (dout !== 8'h03) begin
            n_err++;
            $display("FAIL retention@2: dout=%h required=03", dout);
        end
        op(1'b1, 1'b0, 6'd63, 8'h00);
        n_cmp++;
        if (dout !== 8'h55) begin
            n_err++;
            $display("FAIL retention@63: dout=%h required=55", dout);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = '0;
        data  = '0;
        test_reset();
        test_sequential_writes();
        test_readback();
        test_back_to_back();
        test_overwrite_boundary();
        test_reset_retention();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
